pcie_cpl_sched: RTL and testbench
=================================

Name: pcie_cpl_sched

Overview:
- Completion scheduler for the PCIe TX completion engine. Shares the single engine between N requesters (target read handlers, status/register readback) with round-robin arbitration.
- Tracks the one in-flight completion and runs the power-management quiesce sequence. When a PME_Turn_Off arrives, it stops granting, drains the in-flight completion, then acknowledges turn-off.
- Sits between the user request sources and the TX engine / PCIe core cfg interface.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TMO_CYCLES, 1024, watchdog limit in clk cycles from tx_start_o to tx_done_i.
- TMO_W, 10, width of the watchdog counter; must satisfy 2^TMO_W >= TMO_CYCLES.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  N_REQ  per-requester completion request, level, held until granted.
- gnt_o  out  N_REQ  one-hot grant, held for the whole transaction.
- tx_start_o  out  1  one-cycle pulse starting the TX engine for the granted requester.
- tx_done_i  in  1  one-cycle pulse from the TX engine marking completion sent.
- cfg_to_turnoff_n_i  in  1  active-low PME_Turn_Off notification from the PCIe core.
- cfg_turnoff_ok_n_o  out  1  active-low turn-off acknowledge to the PCIe core.
- busy_o  out  1  high while a completion is in flight.
- tmo_err_o  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset is rst_n, asynchronous, active-low; the clock is clk. All state is cleared asynchronously.
- Reset values: state=IDLE, gnt_o=0, tx_start_o=0, cfg_turnoff_ok_n_o=1, busy_o=0, tmo_err_o=0, rr pointer=0, watchdog=0.
- All outputs are registered.
- States: IDLE, WAIT, OFF.
- IDLE, turn-off pending: if cfg_to_turnoff_n_i=0, go to OFF. This check has priority over any req_i sampled in the same cycle.
- IDLE, request pending: else if any req_i=1, select a winner by round-robin starting from the rr pointer. Set gnt_o to the winner one-hot, pulse tx_start_o, set busy_o=1, clear the watchdog and go to WAIT.
  - Latency: req sampled at edge k, so gnt_o and tx_start_o are high after edge k+1.
- Round-robin: after a grant to index i, the rr pointer becomes (i+1) mod N_REQ. The search wraps modulo N_REQ. A single active requester is granted back-to-back with one IDLE cycle between grants.
- WAIT, done: tx_done_i=1 sets gnt_o=0 and busy_o=0 and returns to IDLE.
  - Earliest regrant is 2 cycles after tx_done_i.
  - tx_done_i is ignored in IDLE and OFF, and in the tx_start_o cycle itself; that cycle is counted as WAIT cycle 0.
- WAIT, timeout: the watchdog increments every WAIT cycle. On reaching TMO_CYCLES-1 without tx_done_i, pulse tmo_err_o, clear gnt_o and busy_o, and return to IDLE.
  - If tx_done_i and expiry coincide, tx_done_i wins and there is no error pulse.
- WAIT, turn-off: cfg_to_turnoff_n_i=0 in WAIT does not abort. The transaction drains and IDLE then enters OFF on the next cycle.
- OFF: cfg_turnoff_ok_n_o=0 (registered, one cycle after entry). No grants; req_i is ignored.
  - When cfg_to_turnoff_n_i returns to 1, drive cfg_turnoff_ok_n_o=1 and go to IDLE.
  - Pending requests are then served with the rr pointer preserved.
- Requester dropping req_i while granted: ignored; the grant persists until tx_done_i or timeout.
- Reset mid-transaction: everything returns to reset values immediately, and the TX engine must be reset alongside.

Decomposition:
- Shared package/include (pcie_def): state encodings (IDLE=2'd0, WAIT=2'd1, OFF=2'd2) and the default TMO_CYCLES constant.
- One sub-module, pcie_rr_arb: combinational round-robin picker. Inputs are req vector and pointer; outputs are one-hot winner and index. The pointer register stays in the parent.

Test Plan (N_REQ=4, TMO_CYCLES=16):
- Single request: req_i=4'b0100 at edge k -> gnt_o=4'b0100 and tx_start_o pulse after edge k+1. tx_done_i 5 cycles later -> gnt_o=0 and busy_o=0 the next cycle.
- Fairness: req_i=4'b1111 held, tx_done_i 3 cycles after each start -> grant order 0,1,2,3,0. Exactly one tx_start_o per grant.
- Turn-off while idle: cfg_to_turnoff_n_i=0 with req_i=4'b0001 in the same cycle -> no grant, cfg_turnoff_ok_n_o=0 two cycles later. Deassert turnoff -> ok_n=1, then gnt_o=4'b0001.
- Turn-off during WAIT: turnoff asserted 2 cycles after tx_start_o, tx_done_i 4 cycles later -> ok_n stays 1 until drain, then goes 0. No new grant while in OFF.
- Watchdog: grant with no tx_done_i -> tmo_err_o pulse exactly once, gnt_o=0. Coincident done and expiry -> no tmo_err_o.
- Async reset asserted in WAIT -> gnt_o=0, busy_o=0, ok_n=1 immediately without waiting for a clock. After release, the first grant goes to index 0.

Source files
------------

// File: rtl/pcie_cpl_sched_pkg.sv
// Shared definitions for the PCIe completion scheduler: FSM encodings and defaults.
// Pure declarations, no logic.
package pcie_cpl_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OFF  = 2'd2
    } sched_state_t;

    localparam int TMO_CYCLES_DEF = 1024;

endpackage

// File: rtl/pcie_cpl_sched_if.sv
// Request/grant, TX engine and PCIe cfg power-management signals of the completion scheduler.
// master = scheduler side, slave = requesters / TX engine / PCIe core side.
interface pcie_cpl_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] gnt_o;
    logic             tx_start_o;
    logic             tx_done_i;
    logic             cfg_to_turnoff_n_i;
    logic             cfg_turnoff_ok_n_o;
    logic             busy_o;
    logic             tmo_err_o;

    modport master (
        input  req_i, tx_done_i, cfg_to_turnoff_n_i,
        output gnt_o, tx_start_o, cfg_turnoff_ok_n_o, busy_o, tmo_err_o
    );

    modport slave (
        output req_i, tx_done_i, cfg_to_turnoff_n_i,
        input  gnt_o, tx_start_o, cfg_turnoff_ok_n_o, busy_o, tmo_err_o
    );
endinterface

// File: rtl/pcie_rr_arb.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping modulo N_REQ.
// Zero latency; win_oh is all-zero when no request is active.
module pcie_rr_arb #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx
);
    logic             found;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        found    = 1'b0;
        win_oh   = '0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand     = (int'(ptr) + k) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found            = 1'b1;
                win_idx          = cand_idx;
                win_oh[cand_idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pcie_cpl_sched.sv
// Round-robin completion scheduler with in-flight watchdog and PME_Turn_Off quiesce.
// Grant one cycle after request; one completion in flight, requests wait (held level) until granted.
module pcie_cpl_sched
    import pcie_cpl_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TMO_CYCLES = TMO_CYCLES_DEF,
    parameter int TMO_W      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    pcie_cpl_sched_if.master bus
);
    localparam int               IDX_W   = $clog2(N_REQ);
    localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(TMO_CYCLES - 1);

    sched_state_t     state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             start_q, start_d;
    logic             ok_n_q, ok_n_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [TMO_W-1:0] wd_q, wd_d;

    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;

    pcie_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req     (bus.req_i),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            start_q <= 1'b0;
            ok_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ptr_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            ok_n_q  <= ok_n_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        start_d = 1'b0;
        ok_n_d  = ok_n_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                // Turn-off is checked first so no new completion starts once quiesce is requested.
                if (!bus.cfg_to_turnoff_n_i) begin
                    state_d = ST_OFF;
                end else if (|bus.req_i) begin
                    gnt_d   = win_oh;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    wd_d    = '0;
                    ptr_d   = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done coinciding with the start pulse belongs to no transaction of ours.
                if (bus.tx_done_i && !start_q) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_OFF: begin
                if (bus.cfg_to_turnoff_n_i) begin
                    ok_n_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ok_n_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.gnt_o              = gnt_q;
    assign bus.tx_start_o         = start_q;
    assign bus.cfg_turnoff_ok_n_o = ok_n_q;
    assign bus.busy_o             = busy_q;
    assign bus.tmo_err_o          = tmo_q;
endmodule

// File: tb/tb_pcie_cpl_sched.sv
// Directed bench for pcie_cpl_sched (N_REQ=4, TMO_CYCLES=16): vector table plus
// hand-written sequences for fairness, watchdog and asynchronous reset.
module tb_pcie_cpl_sched;

    logic clk;
    logic rst_n;

    pcie_cpl_sched_if #(.N_REQ(4)) bus ();

    pcie_cpl_sched #(
        .N_REQ      (4),
        .TMO_CYCLES (16),
        .TMO_W      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic       to_n;
        logic [3:0] gnt;
        logic       start;
        logic       ok_n;
        logic       busy;
        logic       tmo;
    } vec_t;

    localparam int NV = 30;
    vec_t vt[NV];

    int n_tests   = 0;
    int n_fail    = 0;
    int start_cnt = 0;
    int tmo_cnt   = 0;

    function automatic vec_t mv(logic [3:0] r, logic d, logic t,
                                logic [3:0] g, logic s, logic ok, logic b, logic e);
        vec_t v;
        v.req = r; v.done = d; v.to_n = t;
        v.gnt = g; v.start = s; v.ok_n = ok; v.busy = b; v.tmo = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [3:0] g, input logic s,
                            input logic ok, input logic b, input logic e);
        chk({nm, ".gnt"},   32'(bus.gnt_o), 32'(g));
        chk({nm, ".start"}, 32'(bus.tx_start_o), 32'(s));
        chk({nm, ".ok_n"},  32'(bus.cfg_turnoff_ok_n_o), 32'(ok));
        chk({nm, ".busy"},  32'(bus.busy_o), 32'(b));
        chk({nm, ".tmo"},   32'(bus.tmo_err_o), 32'(e));
    endtask

    // Drive inputs for one clock edge, then look at the outputs 1 ns after it.
    task automatic apply(input logic [3:0] r, input logic d, input logic t);
        bus.req_i              = r;
        bus.tx_done_i          = d;
        bus.cfg_to_turnoff_n_i = t;
        @(posedge clk);
        #1;
        if (bus.tx_start_o) start_cnt++;
        if (bus.tmo_err_o)  tmo_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int order[5];

        // single request with a done in the start cycle (ignored), then done 5 cycles on
        vt[0]  = mv(4'b0100, 0, 1, 4'b0100, 1, 1, 1, 0);
        vt[1]  = mv(4'b0000, 1, 1, 4'b0100, 0, 1, 1, 0);
        vt[2]  = mv(4'b0000, 0, 1, 4'b0100, 0, 1, 1, 0);
        vt[3]  = mv(4'b0000, 0, 1, 4'b0100, 0, 1, 1, 0);
        vt[4]  = mv(4'b0000, 0, 1, 4'b0100, 0, 1, 1, 0);
        vt[5]  = mv(4'b0000, 0, 1, 4'b0100, 0, 1, 1, 0);
        vt[6]  = mv(4'b0000, 1, 1, 4'b0000, 0, 1, 0, 0);
        vt[7]  = mv(4'b0000, 1, 1, 4'b0000, 0, 1, 0, 0);
        // turn-off while idle beats a same-cycle request; ptr=3 wraps to 0 afterwards
        vt[8]  = mv(4'b0001, 0, 0, 4'b0000, 0, 1, 0, 0);
        vt[9]  = mv(4'b0001, 0, 0, 4'b0000, 0, 0, 0, 0);
        vt[10] = mv(4'b0001, 0, 0, 4'b0000, 0, 0, 0, 0);
        vt[11] = mv(4'b0001, 0, 1, 4'b0000, 0, 1, 0, 0);
        vt[12] = mv(4'b0001, 0, 1, 4'b0001, 1, 1, 1, 0);
        vt[13] = mv(4'b0000, 0, 1, 4'b0001, 0, 1, 1, 0);
        vt[14] = mv(4'b0000, 1, 1, 4'b0000, 0, 1, 0, 0);
        // turn-off 2 cycles into WAIT, done 4 cycles later, then OFF ignores req
        vt[15] = mv(4'b1000, 0, 1, 4'b1000, 1, 1, 1, 0);
        vt[16] = mv(4'b0000, 0, 1, 4'b1000, 0, 1, 1, 0);
        vt[17] = mv(4'b0000, 0, 1, 4'b1000, 0, 1, 1, 0);
        vt[18] = mv(4'b0000, 0, 0, 4'b1000, 0, 1, 1, 0);
        vt[19] = mv(4'b0000, 0, 0, 4'b1000, 0, 1, 1, 0);
        vt[20] = mv(4'b0000, 0, 0, 4'b1000, 0, 1, 1, 0);
        vt[21] = mv(4'b0000, 0, 0, 4'b1000, 0, 1, 1, 0);
        vt[22] = mv(4'b0001, 1, 0, 4'b0000, 0, 1, 0, 0);
        vt[23] = mv(4'b0001, 0, 0, 4'b0000, 0, 1, 0, 0);
        vt[24] = mv(4'b0001, 0, 0, 4'b0000, 0, 0, 0, 0);
        vt[25] = mv(4'b0001, 0, 0, 4'b0000, 0, 0, 0, 0);
        vt[26] = mv(4'b0001, 0, 1, 4'b0000, 0, 1, 0, 0);
        vt[27] = mv(4'b0001, 0, 1, 4'b0001, 1, 1, 1, 0);
        vt[28] = mv(4'b0000, 0, 1, 4'b0001, 0, 1, 1, 0);
        vt[29] = mv(4'b0000, 1, 1, 4'b0000, 0, 1, 0, 0);

        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

        rst_n                  = 1'b0;
        bus.req_i              = '0;
        bus.tx_done_i          = 1'b0;
        bus.cfg_to_turnoff_n_i = 1'b1;
        #12;
        chk_outs("reset", 4'b0000, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(vt[i].req, vt[i].done, vt[i].to_n);
            chk_outs($sformatf("vec%0d", i), vt[i].gnt, vt[i].start, vt[i].ok_n, vt[i].busy, vt[i].tmo);
        end

        // asynchronous reset while a completion is in flight (ptr=1 -> index 1)
        apply(4'b0010, 0, 1);
        chk("arst.pre_gnt", 32'(bus.gnt_o), 32'h2);
        apply(4'b0000, 0, 1);
        apply(4'b0000, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_outs("arst", 4'b0000, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fairness from a freshly reset pointer: 0,1,2,3,0, done 3 cycles after each start
        start_cnt = 0;
        for (int g = 0; g < 5; g++) begin
            cyc = 0;
            do begin
                apply(4'b1111, 0, 1);
                cyc++;
            end while (!bus.tx_start_o && cyc < 10);
            chk($sformatf("fair%0d.started", g), 32'(bus.tx_start_o), 32'h1);
            chk($sformatf("fair%0d.gnt", g), 32'(bus.gnt_o), 32'(4'b0001 << order[g]));
            apply(4'b1111, 0, 1);
            apply(4'b1111, 0, 1);
            apply(4'b1111, 0, 1);
            chk($sformatf("fair%0d.held", g), 32'(bus.gnt_o), 32'(4'b0001 << order[g]));
            apply((g == 4) ? 4'b0000 : 4'b1111, 1, 1);
            chk($sformatf("fair%0d.released", g), 32'(bus.gnt_o), 32'h0);
        end
        apply(4'b0000, 0, 1);
        apply(4'b0000, 0, 1);
        chk("fair.start_count", 32'(start_cnt), 32'd5);

        // watchdog expiry: ptr=1, no done at all
        tmo_cnt = 0;
        apply(4'b0010, 0, 1);
        chk("wd.gnt", 32'(bus.gnt_o), 32'h2);
        cyc = 0;
        while (!bus.tmo_err_o && cyc < 40) begin
            apply(4'b0000, 0, 1);
            cyc++;
        end
        chk("wd.latency", 32'(cyc), 32'd16);
        chk_outs("wd.expired", 4'b0000, 0, 1, 0, 1);
        apply(4'b0000, 0, 1);
        apply(4'b0000, 1, 1);
        apply(4'b0000, 0, 1);
        chk("wd.pulse_count", 32'(tmo_cnt), 32'd1);

        // done on the expiry cycle wins: ptr=2
        tmo_cnt = 0;
        apply(4'b0100, 0, 1);
        chk("wdc.gnt", 32'(bus.gnt_o), 32'h4);
        for (int c = 0; c < 15; c++) apply(4'b0000, 0, 1);
        chk("wdc.still_held", 32'(bus.gnt_o), 32'h4);
        apply(4'b0000, 1, 1);
        chk_outs("wdc.done", 4'b0000, 0, 1, 0, 0);
        apply(4'b0000, 0, 1);
        chk("wdc.no_tmo", 32'(tmo_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
